mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one port of the dual-port block RAM between two requesters (e.g. the datapath's load/store unit and a display/DMA reader) using round-robin arbitration. It sits between the requesters and the RAM's port signals (we, address, dataIn, dataOut), so several masters can use one physical port. It issues at most one RAM access per cycle, returns read data with a fixed latency, and never issues a request twice.

## Interface
Parameters:
- DATA_W, 16, RAM word width
- ADDR_W, 8, RAM address width

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- req0, req1  in  1  access request from requester 0/1
- we0, we1  in  1  1 = write, 0 = read; qualified by req
- addr0, addr1  in  ADDR_W  access address
- wdata0, wdata1  in  DATA_W  write data
- gnt0, gnt1  out  1  one-cycle pulse: request accepted and issued to RAM
- rvalid0, rvalid1  out  1  one-cycle pulse: rdata holds read result for that requester
- rdata  out  DATA_W  read data, shared by both requesters; qualified by rvalid
- mem_we  out  1  RAM port write enable
- mem_addr  out  ADDR_W  RAM port address
- mem_din  out  DATA_W  RAM port write data
- mem_dout  in  DATA_W  RAM port read data; synchronous, valid one cycle after the address is presented

## Operation
- Eligibility at each edge: eligible_i = req_i & ~gnt_i. A requester granted in the current cycle cannot win at the next edge; this prevents a double issue while the requester drops req.
- Arbitration is round-robin and uses a 1-bit `last` pointer (the ID of the last winner):
  - One requester eligible: that requester wins.
  - Both eligible: the requester ≠ last wins.
  - None eligible: no issue.
- On an edge with a winner w:
  - mem_addr/mem_we/mem_din <= addr_w/we_w/wdata_w.
  - gnt_w <= 1.
  - last <= w.
- On an edge with no winner: mem_we <= 0, gnt <= 0. mem_addr and mem_din hold their values.
- Response tracking: a 2-stage shift of {valid, is_read, id} follows each issue. rvalid_id pulses when the stage-2 entry is a valid read. rdata is a combinational pass-through of mem_dout.
- Writes produce gnt only, never rvalid.
- Requester contract: hold req/we/addr/wdata stable until gnt is seen high, then either drop req or present the next request at the following edge.
- Reset (rst=0, asynchronous):
  - gnt0/1, rvalid0/1, mem_we, and pipeline valids = 0.
  - mem_addr = 0, mem_din = 0, last = 1, so requester 0 wins the first tie.
- A reset mid-operation drops any in-flight read response. No rvalid follows reset release until a new grant.

## Timing
- Request sampled at edge E0 → gnt and mem_* registered at E0 (visible in cycle C0).
- RAM samples the address at E1 → mem_dout valid in C1. rvalid and rdata are valid in C1, one cycle after gnt.
- Read latency from the granting edge: 2 edges. A write commits at E1.
- Throughput: 1 access/cycle with both requesters active, alternating 0,1,0,1. A single requester holding req continuously gets 1 access per 2 cycles.
- A read issued the cycle after a write to the same address returns the new data, because both go in order on the same port.
- rvalid0 and rvalid1 are never high in the same cycle. gnt0 and gnt1 are never high in the same cycle.

## Structure
- Shared package mem_pkg: DATA_W, ADDR_W defaults and a requester-ID type (1 bit). It is reused by the RAM wrapper and other memory FSMs.
- Sub-module rr_pick2: combinational two-way round-robin picker. Inputs are eligible[1:0] and last; outputs are win_valid and win_id. The top level holds all registers: `last`, the mem_* outputs, gnt, and the response pipeline.

## Test plan
- Reset release, then req0 read at addr 0x00 (RAM preloaded 0x0001) → gnt0 one cycle later; rvalid0 with rdata=0x0001 the cycle after gnt0. No gnt1/rvalid1.
- req0 and req1 both held high continuously, reads at 0x01/0x02 → grants strictly alternate 0,1,0,1 starting with 0. rvalid follows each gnt by exactly 1 cycle with the matching data (0x0002/0x0003).
- req0 write 0x0004 to 0x00 then immediate read of 0x00 → two gnt0 pulses 2 cycles apart, rvalid0 with rdata=0x0004, and mem_we high for exactly one cycle.
- req1 alone held high for 6 cycles → gnt1 pulses every other cycle (3 grants) and is never on consecutive cycles.
- Write by req1 of 0x0005 at 0xFF simultaneous with read by req0 at 0xFF, last=0 → req1 granted first, then req0 reads 0x0005.
- Reset asserted the cycle after a read gnt → no rvalid afterwards. All outputs are 0 during reset. After release the first tie goes to requester 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-subsystem definitions: default RAM geometry and requester/response types.
package mem_pkg;
  localparam int MEM_DATA_W = 16;
  localparam int MEM_ADDR_W = 8;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    logic    is_read;
    req_id_t id;
  } rsp_t;
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker; the requester that did not win last time takes a tie.
module rr_pick2
  import mem_pkg::*;
(
  input  logic [1:0] eligible,
  input  req_id_t    last,
  output logic       win_valid,
  output req_id_t    win_id
);

  assign win_valid = |eligible;
  assign win_id    = (&eligible) ? ~last : eligible[1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one synchronous RAM port between two requesters, with
// in-order read response tracking.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  logic [1:0]        r_gnt;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_din;
  req_id_t           r_last;
  rsp_t              r_s1;
  rsp_t              r_s2;

  logic [1:0]        w_eligible;
  logic              w_win_valid;
  req_id_t           w_win_id;
  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;

  // A requester granted this cycle sits out the next edge so a held req is not issued twice.
  assign w_eligible = {req1 & ~r_gnt[1], req0 & ~r_gnt[0]};

  rr_pick2 u_pick (
    .eligible  (w_eligible),
    .last      (r_last),
    .win_valid (w_win_valid),
    .win_id    (w_win_id)
  );

  assign w_win_we    = w_win_id ? we1    : we0;
  assign w_win_addr  = w_win_id ? addr1  : addr0;
  assign w_win_wdata = w_win_id ? wdata1 : wdata0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt      <= 2'b00;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_last     <= 1'b1;
      r_s1       <= '0;
      r_s2       <= '0;
    end else begin
      r_s2 <= r_s1;
      if (w_win_valid) begin
        r_gnt      <= w_win_id ? 2'b10 : 2'b01;
        r_mem_we   <= w_win_we;
        r_mem_addr <= w_win_addr;
        r_mem_din  <= w_win_wdata;
        r_last     <= w_win_id;
        r_s1       <= '{valid: 1'b1, is_read: ~w_win_we, id: w_win_id};
      end else begin
        r_gnt    <= 2'b00;
        r_mem_we <= 1'b0;
        r_s1     <= '0;
      end
    end
  end

  // Stage 2 lines up with the RAM's registered read data.
  assign rvalid0  = r_s2.valid & r_s2.is_read & (r_s2.id == 1'b0);
  assign rvalid1  = r_s2.valid & r_s2.is_read & (r_s2.id == 1'b1);
  assign rdata    = mem_dout;
  assign gnt0     = r_gnt[0];
  assign gnt1     = r_gnt[1];
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle table for grants, scoreboard for read responses.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [7:0]  addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [15:0] rdata, mem_din;
  logic [7:0]  mem_addr;
  logic [15:0] mem_dout = '0;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.DATA_W(16), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Synchronous RAM port: read-first, data valid the cycle after the address.
  logic [15:0] ram [256];
  logic        ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= 16'(i + 1);
      ram_init <= 1'b1;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs as the DUT saw them at the last rising edge.
  logic        c_we0, c_we1;
  logic [7:0]  c_a0, c_a1;
  logic [15:0] c_d0, c_d1;
  always @(posedge clk) begin
    c_we0 <= we0; c_a0 <= addr0; c_d0 <= wdata0;
    c_we1 <= we1; c_a1 <= addr1; c_d1 <= wdata1;
  end

  typedef struct {
    logic        id;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] model [256];
  logic        mdl_init = 1'b0;
  int          cyc = 0;

  always @(negedge clk) begin
    exp_t e;
    cyc <= cyc + 1;
    if (!mdl_init) begin
      for (int i = 0; i < 256; i++) model[i] <= 16'(i + 1);
      mdl_init <= 1'b1;
    end
    if (!rst) begin
      sbq.delete();
    end else begin
      chk("rvalid_exclusive", 32'(rvalid0 & rvalid1), 32'd0);
      chk("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
      if (rvalid0 || rvalid1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rvalid", 32'(1), 32'(0));
        end else begin
          e = sbq.pop_front();
          chk("rsp_id", 32'(rvalid1), 32'(e.id));
          chk("rsp_data", 32'(rdata), 32'(e.data));
          chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        chk("missing_rvalid", 32'(0), 32'(1));
      end
      if (gnt0) begin
        if (c_we0) model[c_a0] <= c_d0;
        else sbq.push_back('{id: 1'b0, data: model[c_a0], cyc: cyc + 1});
      end
      if (gnt1) begin
        if (c_we1) model[c_a1] <= c_d1;
        else sbq.push_back('{id: 1'b1, data: model[c_a1], cyc: cyc + 1});
      end
    end
  end

  typedef struct {
    logic r0, w0; logic [7:0] a0; logic [15:0] d0;
    logic r1, w1; logic [7:0] a1; logic [15:0] d1;
    logic eg0, eg1, ewe;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r0, logic w0, logic [7:0] a0, logic [15:0] d0,
                              logic r1, logic w1, logic [7:0] a1, logic [15:0] d1,
                              logic eg0, logic eg1, logic ewe);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.eg0 = eg0; v.eg1 = eg1; v.ewe = ewe;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt0"}, 32'(gnt0), 32'd0);
    chk({tag, "_gnt1"}, 32'(gnt1), 32'd0);
    chk({tag, "_rvalid0"}, 32'(rvalid0), 32'd0);
    chk({tag, "_rvalid1"}, 32'(rvalid1), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_din"}, 32'(mem_din), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idle;
    idle = mk(0,0,8'h00,16'h0, 0,0,8'h00,16'h0, 0,0,0);
    vecs.push_back(idle);
    // single read by requester 0
    vecs.push_back(mk(1,0,8'h00,16'h0, 0,0,8'h00,16'h0, 1,0,0));
    vecs.push_back(idle);
    vecs.push_back(idle);
    // requester 1 alone, held six cycles
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(0,0,8'h00,16'h0, 1,0,8'h02,16'h0, 0,(i % 2 == 0),0));
    vecs.push_back(idle);
    // both held: strict alternation starting with 0
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(1,0,8'h01,16'h0, 1,0,8'h02,16'h0, (i % 2 == 0),(i % 2 == 1),0));
    vecs.push_back(idle);
    vecs.push_back(idle);
    // write 0x0004 to 0x00 then read it back
    vecs.push_back(mk(1,1,8'h00,16'h0004, 0,0,8'h00,16'h0, 1,0,1));
    vecs.push_back(mk(1,0,8'h00,16'h0000, 0,0,8'h00,16'h0, 0,0,0));
    vecs.push_back(mk(1,0,8'h00,16'h0000, 0,0,8'h00,16'h0, 1,0,0));
    vecs.push_back(idle);
    vecs.push_back(idle);
    // last=0: write by 1 to 0xFF wins the tie, then 0 reads the new value
    vecs.push_back(mk(1,0,8'hFF,16'h0, 1,1,8'hFF,16'h0005, 0,1,1));
    vecs.push_back(mk(1,0,8'hFF,16'h0, 0,0,8'h00,16'h0000, 1,0,0));
    vecs.push_back(idle);
    vecs.push_back(idle);
    vecs.push_back(idle);

    repeat (3) @(negedge clk);
    chk_reset_outputs("in_reset");
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("row%0d_gnt0", i), 32'(gnt0), 32'(vecs[i].eg0));
      chk($sformatf("row%0d_gnt1", i), 32'(gnt1), 32'(vecs[i].eg1));
      chk($sformatf("row%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].ewe));
    end

    // reset while a read is in flight
    drive(mk(1,0,8'h01,16'h0, 0,0,8'h00,16'h0, 0,0,0));
    @(negedge clk);
    chk("pre_rst_gnt0", 32'(gnt0), 32'd1);
    chk("pre_rst_mem_addr", 32'(mem_addr), 32'h01);
    drive(idle);
    rst = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    repeat (2) @(negedge clk);
    chk_reset_outputs("held_rst");
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_rvalid0_%0d", i), 32'(rvalid0), 32'd0);
      chk($sformatf("post_rst_rvalid1_%0d", i), 32'(rvalid1), 32'd0);
    end

    // first tie after reset goes to requester 0
    drive(mk(1,0,8'h01,16'h0, 1,0,8'h02,16'h0, 0,0,0));
    @(negedge clk);
    chk("tie_after_rst_gnt0", 32'(gnt0), 32'd1);
    chk("tie_after_rst_gnt1", 32'(gnt1), 32'd0);
    drive(mk(0,0,8'h00,16'h0, 1,0,8'h02,16'h0, 0,0,0));
    @(negedge clk);
    chk("tie_after_rst_next_gnt1", 32'(gnt1), 32'd1);
    drive(idle);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
